// File: rtl/ram_burst_reader_if.sv
// Bundle of the burst request, RAM read port and output stream signals.
// Handshakes: a transfer happens on a rising clk edge where both valid and
// ready are high. Once valid is raised it stays high, with stable payload,
// until the matching ready is seen. The RAM port has no ready: rd_data is
// valid the cycle after rd_en.
interface ram_burst_reader_if #(
  parameter int WIDTH      = 32,
  parameter int DEPTH      = 512,
  parameter int ADDR_WIDTH = $clog2(DEPTH),
  parameter int LEN_WIDTH  = ADDR_WIDTH + 1
);
  logic                  req_valid;
  logic                  req_ready;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [LEN_WIDTH-1:0]  req_len;
  logic                  ram_rd_en;
  logic [ADDR_WIDTH-1:0] ram_rd_addr;
  logic [WIDTH-1:0]      ram_rd_data;
  logic                  out_valid;
  logic                  out_ready;
  logic [WIDTH-1:0]      out_data;
  logic                  out_last;
  logic                  busy;
  logic                  done;
  logic [1:0]            dbg_state;

  // View of the reader block itself.
  modport master (
    input  req_valid, req_addr, req_len, ram_rd_data, out_ready,
    output req_ready, ram_rd_en, ram_rd_addr, out_valid, out_data, out_last,
           busy, done, dbg_state
  );

  // View of the surrounding requester, RAM and stream consumer.
  modport slave (
    output req_valid, req_addr, req_len, ram_rd_data, out_ready,
    input  req_ready, ram_rd_en, ram_rd_addr, out_valid, out_data, out_last,
           busy, done, dbg_state
  );
endinterface

// File: rtl/ram_burst_reader.sv
// Burst reader: turns (address, length) requests into one RAM read per cycle
// and returns the words as a valid/ready stream with a last marker. A
// 2-entry FIFO plus a credit check on issue means a returning RAM word always
// has a slot, so backpressure never drops data.
module ram_burst_reader #(
  parameter int WIDTH      = 32,
  parameter int DEPTH      = 512,
  parameter int ADDR_WIDTH = $clog2(DEPTH),
  parameter int LEN_WIDTH  = ADDR_WIDTH + 1
) (
  input logic               clk,
  input logic               rst,
  ram_burst_reader_if.master bus
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_BUSY   = 2'd1,
    ST_FINISH = 2'd2
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

  state_t                state_q;
  logic                  req_ready_q;
  logic                  busy_q;
  logic                  done_q;
  logic [ADDR_WIDTH-1:0] issue_addr_q;
  logic [LEN_WIDTH-1:0]  issue_left_q;
  logic [LEN_WIDTH-1:0]  beat_left_q;

  logic [WIDTH-1:0]      fifo_mem_q [2];
  logic                  wr_ptr_q;
  logic                  rd_ptr_q;
  logic [1:0]            count_q;
  logic                  inflight_q;

  logic                  accept;
  logic                  push;
  logic                  pop;
  logic                  out_valid;
  logic                  rd_en;
  logic [2:0]            credit_used;
  logic [ADDR_WIDTH-1:0] issue_addr_d;

  assign accept    = req_ready_q && bus.req_valid;
  assign push      = inflight_q;
  assign out_valid = (count_q != 2'd0);
  assign pop       = out_valid && bus.out_ready;

  // Slots already claimed after this cycle's pop: held words plus the read in
  // flight. Only issue when that leaves room for one more returning word.
  assign credit_used = 3'(count_q) + 3'(inflight_q) - 3'(pop);
  assign rd_en = (state_q == ST_BUSY) && (issue_left_q != '0) &&
                 (credit_used < 3'd2);

  // Address walks upward and wraps at the top of the RAM.
  assign issue_addr_d = (issue_addr_q == LAST_ADDR) ? '0
                                                    : issue_addr_q + ADDR_WIDTH'(1);

  assign bus.req_ready   = req_ready_q;
  assign bus.ram_rd_en   = rd_en;
  assign bus.ram_rd_addr = issue_addr_q;
  assign bus.out_valid   = out_valid;
  assign bus.out_data    = fifo_mem_q[rd_ptr_q];
  assign bus.out_last    = out_valid && (beat_left_q == LEN_WIDTH'(1));
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.dbg_state   = state_q;

  // Control FSM with registered status outputs and the burst counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      req_ready_q  <= 1'b1;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      issue_addr_q <= '0;
      issue_left_q <= '0;
      beat_left_q  <= '0;
    end else begin
      case (state_q)
        ST_IDLE, ST_FINISH: begin
          state_q     <= ST_IDLE;
          req_ready_q <= 1'b1;
          busy_q      <= 1'b0;
          done_q      <= 1'b0;
          if (accept) begin
            issue_addr_q <= bus.req_addr;
            issue_left_q <= bus.req_len;
            beat_left_q  <= bus.req_len;
            if (bus.req_len == '0) begin
              // Empty burst completes immediately without touching the RAM.
              state_q <= ST_FINISH;
              done_q  <= 1'b1;
            end else begin
              state_q     <= ST_BUSY;
              busy_q      <= 1'b1;
              req_ready_q <= 1'b0;
            end
          end
        end
        ST_BUSY: begin
          if (rd_en) begin
            issue_addr_q <= issue_addr_d;
            issue_left_q <= issue_left_q - LEN_WIDTH'(1);
          end
          if (pop) begin
            beat_left_q <= beat_left_q - LEN_WIDTH'(1);
            if (beat_left_q == LEN_WIDTH'(1)) begin
              state_q     <= ST_FINISH;
              busy_q      <= 1'b0;
              done_q      <= 1'b1;
              req_ready_q <= 1'b1;
            end
          end
        end
        default: begin
          state_q     <= ST_IDLE;
          req_ready_q <= 1'b1;
          busy_q      <= 1'b0;
          done_q      <= 1'b0;
        end
      endcase
    end
  end

  // Return buffer: capture the word for last cycle's read, release on handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      fifo_mem_q[0] <= '0;
      fifo_mem_q[1] <= '0;
      wr_ptr_q      <= 1'b0;
      rd_ptr_q      <= 1'b0;
      count_q       <= 2'd0;
      inflight_q    <= 1'b0;
    end else begin
      if (push) begin
        fifo_mem_q[wr_ptr_q] <= bus.ram_rd_data;
        wr_ptr_q             <= ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      count_q    <= count_q + 2'(push) - 2'(pop);
      inflight_q <= rd_en;
    end
  end

endmodule

// File: tb/tb_ram_burst_reader.sv
// Bench for ram_burst_reader: a table of per-cycle vectors for the simple
// bursts, then hand-written sequences for backpressure, reset mid-burst and
// back-to-back requests checked against an expected-word queue.
module tb_ram_burst_reader;

  localparam int W  = 32;
  localparam int AW = 9;
  localparam int LW = 10;

  logic clk;
  logic rst;
  logic [W-1:0] mem [512];
  logic [W-1:0] ram_q;

  ram_burst_reader_if #(.WIDTH(W), .DEPTH(512), .ADDR_WIDTH(AW), .LEN_WIDTH(LW)) bus ();

  ram_burst_reader #(.WIDTH(W), .DEPTH(512), .ADDR_WIDTH(AW), .LEN_WIDTH(LW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM model with one cycle of read latency.
  initial ram_q = '0;
  always @(posedge clk) if (bus.ram_rd_en) ram_q <= mem[bus.ram_rd_addr];
  assign bus.ram_rd_data = ram_q;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle vector: inputs for the cycle and the outputs expected in it.
  typedef struct {
    logic          rv;
    logic [AW-1:0] a;
    logic [LW-1:0] l;
    logic          rdy;
    logic          e_rr;
    logic          e_en;
    logic [AW-1:0] e_addr;
    logic          e_v;
    logic [W-1:0]  e_d;
    logic          e_last;
    logic          e_busy;
    logic          e_done;
  } vec_t;

  function automatic vec_t v(input logic rv, input int a, input int l,
                             input logic e_rr, input logic e_en, input int e_addr,
                             input logic e_v, input int e_d, input logic e_last,
                             input logic e_busy, input logic e_done);
    vec_t r;
    r.rv = rv; r.a = AW'(a); r.l = LW'(l); r.rdy = 1'b1;
    r.e_rr = e_rr; r.e_en = e_en; r.e_addr = AW'(e_addr); r.e_v = e_v;
    r.e_d = W'(e_d); r.e_last = e_last; r.e_busy = e_busy; r.e_done = e_done;
    return r;
  endfunction

  vec_t vecs [21];

  // Scoreboard state for the hand-written sequences: {last, data}.
  logic [W:0] exp_q[$];
  int         outstanding = 0;
  int         pop_cnt = 0;
  int         done_cnt = 0;
  logic       stall_prev = 1'b0;
  logic [W-1:0] held = '0;
  logic       acc = 1'b0;

  // One cycle: drive inputs on the falling edge, then check what the DUT shows.
  task automatic cycle(input logic rdy, input logic rv, input logic [AW-1:0] a,
                       input logic [LW-1:0] l);
    logic pop;
    logic [W:0] e;
    @(negedge clk);
    bus.out_ready = rdy; bus.req_valid = rv; bus.req_addr = a; bus.req_len = l;
    #1;
    pop = bus.out_valid && bus.out_ready;
    acc = rv && bus.req_ready;
    if (acc)
      for (int i = 0; i < int'(l); i++)
        exp_q.push_back({(i == int'(l) - 1), mem[(int'(a) + i) % 512]});
    if (bus.ram_rd_en) chk("credit", 64'(outstanding - int'(pop) < 2), 64'(1));
    if (stall_prev) begin
      chk("stall_valid", 64'(bus.out_valid), 64'(1));
      chk("stall_data", 64'(bus.out_data), 64'(held));
    end
    if (pop) begin
      pop_cnt++;
      if (exp_q.size() == 0) begin
        chk("extra_word", 64'(1), 64'(0));
      end else begin
        e = exp_q.pop_front();
        chk("word_data", 64'(bus.out_data), 64'(e[W-1:0]));
        chk("word_last", 64'(bus.out_last), 64'(e[W]));
      end
    end
    if (bus.done) done_cnt++;
    outstanding = outstanding + int'(bus.ram_rd_en) - int'(pop);
    stall_prev = bus.out_valid && !rdy;
    held = bus.out_data;
  endtask

  initial begin
    for (int i = 0; i < 512; i++) mem[i] = W'(i + 100);

    // Basic burst addr=10 len=4.
    vecs[0]  = v(1, 10, 4, 1, 0, 0,  0, 0,   0, 0, 0);
    vecs[1]  = v(0, 0,  0, 0, 1, 10, 0, 0,   0, 1, 0);
    vecs[2]  = v(0, 0,  0, 0, 1, 11, 0, 0,   0, 1, 0);
    vecs[3]  = v(0, 0,  0, 0, 1, 12, 1, 110, 0, 1, 0);
    vecs[4]  = v(0, 0,  0, 0, 1, 13, 1, 111, 0, 1, 0);
    vecs[5]  = v(0, 0,  0, 0, 0, 14, 1, 112, 0, 1, 0);
    vecs[6]  = v(0, 0,  0, 0, 0, 14, 1, 113, 1, 1, 0);
    vecs[7]  = v(0, 0,  0, 1, 0, 14, 0, 0,   0, 0, 1);
    vecs[8]  = v(0, 0,  0, 1, 0, 14, 0, 0,   0, 0, 0);
    // Zero-length burst.
    vecs[9]  = v(1, 5,  0, 1, 0, 14, 0, 0,   0, 0, 0);
    vecs[10] = v(0, 0,  0, 1, 0, 5,  0, 0,   0, 0, 1);
    vecs[11] = v(0, 0,  0, 1, 0, 5,  0, 0,   0, 0, 0);
    // Wrapping burst addr=510 len=4.
    vecs[12] = v(1, 510, 4, 1, 0, 5,   0, 0,   0, 0, 0);
    vecs[13] = v(0, 0,   0, 0, 1, 510, 0, 0,   0, 1, 0);
    vecs[14] = v(0, 0,   0, 0, 1, 511, 0, 0,   0, 1, 0);
    vecs[15] = v(0, 0,   0, 0, 1, 0,   1, 610, 0, 1, 0);
    vecs[16] = v(0, 0,   0, 0, 1, 1,   1, 611, 0, 1, 0);
    vecs[17] = v(0, 0,   0, 0, 0, 2,   1, 100, 0, 1, 0);
    vecs[18] = v(0, 0,   0, 0, 0, 2,   1, 101, 1, 1, 0);
    vecs[19] = v(0, 0,   0, 1, 0, 2,   0, 0,   0, 0, 1);
    vecs[20] = v(0, 0,   0, 1, 0, 2,   0, 0,   0, 0, 0);

    // Reset.
    rst = 1'b1;
    bus.req_valid = 1'b0; bus.req_addr = '0; bus.req_len = '0; bus.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    chk("rst_req_ready", 64'(bus.req_ready), 64'(1));
    chk("rst_rd_en", 64'(bus.ram_rd_en), 64'(0));
    chk("rst_rd_addr", 64'(bus.ram_rd_addr), 64'(0));
    chk("rst_out_valid", 64'(bus.out_valid), 64'(0));
    chk("rst_out_data", 64'(bus.out_data), 64'(0));
    chk("rst_out_last", 64'(bus.out_last), 64'(0));
    chk("rst_busy", 64'(bus.busy), 64'(0));
    chk("rst_done", 64'(bus.done), 64'(0));
    rst = 1'b0;

    // Table-driven vectors.
    for (int i = 0; i < 21; i++) begin
      @(negedge clk);
      bus.req_valid = vecs[i].rv; bus.req_addr = vecs[i].a;
      bus.req_len = vecs[i].l; bus.out_ready = vecs[i].rdy;
      #1;
      chk($sformatf("v%0d_req_ready", i), 64'(bus.req_ready), 64'(vecs[i].e_rr));
      chk($sformatf("v%0d_rd_en", i), 64'(bus.ram_rd_en), 64'(vecs[i].e_en));
      chk($sformatf("v%0d_rd_addr", i), 64'(bus.ram_rd_addr), 64'(vecs[i].e_addr));
      chk($sformatf("v%0d_out_valid", i), 64'(bus.out_valid), 64'(vecs[i].e_v));
      if (vecs[i].e_v)
        chk($sformatf("v%0d_out_data", i), 64'(bus.out_data), 64'(vecs[i].e_d));
      chk($sformatf("v%0d_out_last", i), 64'(bus.out_last), 64'(vecs[i].e_last));
      chk($sformatf("v%0d_busy", i), 64'(bus.busy), 64'(vecs[i].e_busy));
      chk($sformatf("v%0d_done", i), 64'(bus.done), 64'(vecs[i].e_done));
    end

    // Backpressure: len=6 with out_ready pattern 1,0,0,1,...
    pop_cnt = 0; done_cnt = 0;
    cycle(1'b1, 1'b1, AW'(20), LW'(6));
    chk("bp_accept", 64'(acc), 64'(1));
    for (int k = 0; k < 100 && done_cnt == 0; k++)
      cycle((k % 4 == 0) || (k % 4 == 3), 1'b0, '0, '0);
    chk("bp_done_seen", 64'(done_cnt), 64'(1));
    chk("bp_words", 64'(pop_cnt), 64'(6));
    chk("bp_drained", 64'(exp_q.size()), 64'(0));

    // Reset mid-burst after the third handshake.
    pop_cnt = 0;
    cycle(1'b1, 1'b1, AW'(40), LW'(8));
    for (int k = 0; k < 40 && pop_cnt < 3; k++) cycle(1'b1, 1'b0, '0, '0);
    chk("mr_three_words", 64'(pop_cnt), 64'(3));
    @(negedge clk);
    rst = 1'b1; bus.out_ready = 1'b0;
    @(negedge clk);
    rst = 1'b0; #1;
    chk("mr_out_valid", 64'(bus.out_valid), 64'(0));
    chk("mr_busy", 64'(bus.busy), 64'(0));
    chk("mr_req_ready", 64'(bus.req_ready), 64'(1));
    chk("mr_rd_en", 64'(bus.ram_rd_en), 64'(0));
    exp_q.delete(); outstanding = 0; stall_prev = 1'b0;
    cycle(1'b1, 1'b0, '0, '0);
    chk("mr_late_data", 64'(bus.out_valid), 64'(0));
    pop_cnt = 0; done_cnt = 0;
    cycle(1'b1, 1'b1, AW'(0), LW'(2));
    for (int k = 0; k < 40 && done_cnt == 0; k++) cycle(1'b1, 1'b0, '0, '0);
    chk("mr_new_words", 64'(pop_cnt), 64'(2));
    chk("mr_drained", 64'(exp_q.size()), 64'(0));

    // Back-to-back: second request held during the first burst.
    begin
      logic second_taken;
      logic taken_in_finish;
      second_taken = 1'b0; taken_in_finish = 1'b0;
      pop_cnt = 0; done_cnt = 0;
      cycle(1'b1, 1'b1, AW'(100), LW'(3));
      for (int k = 0; k < 60 && !(second_taken && done_cnt == 2); k++) begin
        cycle(1'b1, !second_taken, AW'(200), LW'(2));
        if (acc) begin
          second_taken = 1'b1;
          taken_in_finish = bus.done;
          chk("b2b_busy_at_accept", 64'(bus.busy), 64'(0));
        end
      end
      chk("b2b_second_taken", 64'(second_taken), 64'(1));
      chk("b2b_in_finish", 64'(taken_in_finish), 64'(1));
      chk("b2b_done_count", 64'(done_cnt), 64'(2));
      chk("b2b_words", 64'(pop_cnt), 64'(5));
      chk("b2b_drained", 64'(exp_q.size()), 64'(0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ram_burst_reader.md
Name: ram_burst_reader

Overview:
- Read-side client for the CGRA subsystem's single-port-read scratch RAMs.
- Accepts a burst request (base address, length) and issues one read per cycle on the RAM's rd_en/rd_addr/rd_data interface, which has 1-cycle read latency.
- Returns the words as a valid/ready stream with a last marker.
- Absorbs downstream backpressure with an internal 2-entry buffer, so no returned word is ever lost.

Parameters:
- WIDTH, 32, data word width; matches the RAM.
- DEPTH, 512, RAM depth in words.
- ADDR_WIDTH, $clog2(DEPTH), RAM address width.
- LEN_WIDTH, ADDR_WIDTH+1, burst length field width; allows a burst of exactly DEPTH words.

Ports:
- clk  in  1  clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  burst request valid.
- req_ready  out  1  reader idle; request accepted on req_valid&&req_ready.
- req_addr  in  ADDR_WIDTH  burst start address.
- req_len  in  LEN_WIDTH  number of words to read; 0 is legal.
- ram_rd_en  out  1  RAM read enable.
- ram_rd_addr  out  ADDR_WIDTH  RAM read address.
- ram_rd_data  in  WIDTH  RAM read data, valid one cycle after ram_rd_en.
- out_valid  out  1  stream word valid.
- out_ready  in  1  stream consumer ready.
- out_data  out  WIDTH  stream word.
- out_last  out  1  marks the final word of the burst.
- busy  out  1  burst in progress.
- done  out  1  one-cycle pulse when the burst completes.

Behaviour:
- Reset (sync, active-high):
  - state=IDLE; FIFO emptied; in-flight flag cleared.
  - req_ready=1; ram_rd_en=0; out_valid=0; out_last=0; busy=0; done=0.
  - out_data=0; ram_rd_addr=0.
- States:
  - IDLE: req_ready=1. On accept, latch issue_addr=req_addr, issue_left=req_len, beat_left=req_len, and go to BUSY. If req_len=0, go to FINISH instead.
  - BUSY: busy=1, req_ready=0. Issue and drain reads as below. Go to FINISH on the edge where the beat with beat_left==1 handshakes.
  - FINISH: done=1 and req_ready=1 for exactly one cycle; the block returns to IDLE behaviour, and a request accepted in this cycle is honoured.
- Issue rule (combinational outputs):
  - ram_rd_en = BUSY && issue_left!=0 && (fifo_count + inflight - pop) < 2, where pop = out_valid && out_ready.
  - ram_rd_addr = issue_addr.
  - On issue: issue_addr increments modulo DEPTH (wraps DEPTH-1 -> 0), issue_left decrements, and inflight is set for the next cycle.
- Capture: when inflight=1, ram_rd_data is pushed into the FIFO at that edge. A push is never refused (guaranteed by the credit rule).
- Output:
  - out_valid = fifo_count != 0; out_data = FIFO head.
  - out_last = out_valid && beat_left==1.
  - beat_left decrements on each handshake.
  - out_data is held stable while out_valid && !out_ready.
- Latency and throughput:
  - Accept at edge E0 -> ram_rd_en high in the next cycle -> out_valid first high after E2.
  - With out_ready held high: one word per cycle sustained.
  - done pulses in the cycle after the last handshake.
- Boundary conditions:
  - Push and pop in the same cycle: the count is unchanged, and FIFO order is preserved.
  - FIFO full: no new reads are issued until a pop occurs.
  - Reset mid-burst: all state is dropped, and the RAM data returning the next cycle is ignored.
  - req_valid while BUSY: ignored; it is not accepted.
  - req_len > DEPTH: addresses wrap and the RAM is re-read; no error is flagged.

Test Plan:
- Basic burst: RAM mem[i]=i+100; request addr=10, len=4, out_ready=1 -> out_data 110,111,112,113 on 4 consecutive cycles; out_last only on 113; first out_valid after 2 edges; done 1 cycle after 113.
- Backpressure: len=6, out_ready toggling 1,0,0,1,... -> all 6 words delivered in order with none dropped or duplicated; ram_rd_en never asserts while fifo_count+inflight-pop>=2; out_data stable while stalled.
- Wrap: DEPTH=512, addr=510, len=4 -> reads at addresses 510,511,0,1, words mem[510],mem[511],mem[0],mem[1].
- Zero length: len=0 -> no ram_rd_en, no out_valid; done=1 the cycle after accept; req_ready=1 throughout.
- Reset mid-burst: len=8, assert rst after the 3rd handshake -> next cycle out_valid=0, busy=0, req_ready=1; the late RAM data does not appear; a new burst addr=0, len=2 then returns mem[0],mem[1] correctly.
- Back-to-back: second request held on req_valid during the first burst -> accepted in the FINISH cycle; its words follow, with out_last marking the end of each burst.
